pipe_trace: RTL and testbench

PIPE_TRACE -- requirements
Module: pipe_trace

---
 rtl/pipe_trace.sv | 142 ++++++++++++++
 tb/tb_pipe_trace.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace.sv
`default_nettype none
// ============================================================================
// Module : pipe_trace
// Desc   : Triggered pipeline trace buffer capturing {pc, if_instr, id_instr}
//          with post-trigger window and sequential readout.
// Rev    : 1.0
// ============================================================================
module pipe_trace #(
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int ADDR_W    = 3,
  parameter int POST_TRIG = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      sample_en,
  input  logic [PC_W-1:0]           pc_in,
  input  logic [INSTR_W-1:0]        if_instr,
  input  logic [INSTR_W-1:0]        id_instr,
  input  logic                      trig_en,
  input  logic [PC_W-1:0]           trig_pc,
  input  logic                      rd_req,
  output logic [PC_W+2*INSTR_W-1:0] rd_data,
  output logic                      rd_valid,
  output logic                      rd_last,
  output logic [1:0]                state,
  output logic [ADDR_W-1:0]         trig_pos
);

  localparam int              c_depth     = 1 << ADDR_W;
  localparam int              c_data_w    = PC_W + 2 * INSTR_W;
  localparam logic [ADDR_W:0] c_depth_cnt = (ADDR_W + 1)'(c_depth);

  localparam logic [1:0] c_s_idle  = 2'd0;
  localparam logic [1:0] c_s_armed = 2'd1;
  localparam logic [1:0] c_s_post  = 2'd2;
  localparam logic [1:0] c_s_done  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_data_w-1:0] r_mem [c_depth];
  logic [ADDR_W-1:0]   r_wptr;
  logic [ADDR_W:0]     r_fill;
  logic [ADDR_W-1:0]   r_post;
  logic [ADDR_W-1:0]   r_rptr;
  logic [ADDR_W:0]     r_remain;
  logic [c_data_w-1:0] r_rd_data;
  logic                r_rd_valid;
  logic                r_rd_last;
  logic [ADDR_W-1:0]   r_trig_pos;

  logic                w_hit;
  logic                w_clear;
  logic                w_wr;
  logic                w_rd_go;
  logic                w_enter_done;
  logic [ADDR_W-1:0]   w_wptr_nxt;
  logic [ADDR_W:0]     w_fill_nxt;

  assign w_hit = sample_en && trig_en && (pc_in == trig_pc);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= c_s_idle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_s_idle:  if (arm) w_state_nxt = c_s_armed;
      c_s_armed: if (w_hit) w_state_nxt = (POST_TRIG == 0) ? c_s_done : c_s_post;
      c_s_post:  if (sample_en && r_post == ADDR_W'(1)) w_state_nxt = c_s_done;
      c_s_done:  if (w_rd_go && r_remain == (ADDR_W + 1)'(1)) w_state_nxt = c_s_idle;
      default:   w_state_nxt = c_s_idle;
    endcase
  end

  // Control outputs of the state machine
  always_comb begin
    w_clear      = (r_state == c_s_idle) && arm;
    w_wr         = ((r_state == c_s_armed) || (r_state == c_s_post)) && sample_en;
    w_rd_go      = (r_state == c_s_done) && rd_req && (r_remain != '0);
    w_enter_done = (w_state_nxt == c_s_done) && (r_state != c_s_done);
  end

  assign w_wptr_nxt = w_wr ? r_wptr + ADDR_W'(1) : r_wptr;
  assign w_fill_nxt = (w_wr && r_fill != c_depth_cnt) ? r_fill + (ADDR_W + 1)'(1) : r_fill;

  // Buffer storage is not reset; reset only blocks the write
  always_ff @(posedge clk) begin
    if (reset && w_wr) r_mem[r_wptr] <= {pc_in, if_instr, id_instr};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_fill     <= '0;
      r_post     <= '0;
      r_rptr     <= '0;
      r_remain   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_trig_pos <= '0;
    end else begin
      r_rd_valid <= w_rd_go;
      r_rd_last  <= w_rd_go && (r_remain == (ADDR_W + 1)'(1));
      if (w_clear) begin
        r_wptr     <= '0;
        r_fill     <= '0;
        r_post     <= '0;
        r_trig_pos <= '0;
      end else begin
        r_wptr <= w_wptr_nxt;
        r_fill <= w_fill_nxt;
        if (r_state == c_s_armed && w_hit) r_post <= ADDR_W'(POST_TRIG);
        else if (r_state == c_s_post && sample_en) r_post <= r_post - ADDR_W'(1);
      end
      // Oldest entry sits at the write pointer once the buffer has wrapped
      if (w_enter_done) begin
        r_rptr     <= (w_fill_nxt == c_depth_cnt) ? w_wptr_nxt : '0;
        r_remain   <= w_fill_nxt;
        r_trig_pos <= ADDR_W'(w_fill_nxt - (ADDR_W + 1)'(POST_TRIG + 1));
      end else if (w_rd_go) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + ADDR_W'(1);
        r_remain  <= r_remain - (ADDR_W + 1)'(1);
      end
    end
  end

  assign state    = r_state;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign trig_pos = r_trig_pos;

endmodule
`default_nettype wire

// File: tb/tb_pipe_trace.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_trace
// Desc   : Directed, table-driven self-checking bench for pipe_trace.
// Rev    : 1.0
// ============================================================================
module tb_pipe_trace;

  logic        clk;
  logic        reset;
  logic        arm;
  logic        sample_en;
  logic [31:0] pc_in;
  logic [31:0] if_instr;
  logic [31:0] id_instr;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic        rd_req;
  logic [95:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic [1:0]  state;
  logic [2:0]  trig_pos;

  int n_cmp;
  int n_err;

  pipe_trace #(.PC_W(32), .INSTR_W(32), .ADDR_W(3), .POST_TRIG(2)) dut (
    .clk(clk), .reset(reset), .arm(arm), .sample_en(sample_en),
    .pc_in(pc_in), .if_instr(if_instr), .id_instr(id_instr),
    .trig_en(trig_en), .trig_pc(trig_pc), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .state(state), .trig_pos(trig_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a;
    logic        se;
    logic        te;
    logic        rq;
    logic [31:0] pc;
    logic [31:0] tpc;
    logic [1:0]  st;
    logic        v;
    logic        l;
    logic [31:0] dpc;
    logic        ctp;
    logic [2:0]  tp;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [95:0] entry(input logic [31:0] pc);
    return {pc, pc ^ 32'hA5A5_0000, ~pc};
  endfunction

  function automatic vec_t mk(input logic a, input logic se, input logic rq,
                              input logic [31:0] pc, input logic [1:0] st,
                              input logic v, input logic l, input logic [31:0] dpc,
                              input logic ctp, input logic [2:0] tp);
    vec_t t;
    t.a = a; t.se = se; t.te = 1'b1; t.rq = rq; t.pc = pc; t.tpc = 32'h04;
    t.st = st; t.v = v; t.l = l; t.dpc = dpc; t.ctp = ctp; t.tp = tp;
    return t;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic se, input logic [31:0] pc,
                       input logic te, input logic [31:0] tpc, input logic rq);
    arm = a; sample_en = se; pc_in = pc; if_instr = pc ^ 32'hA5A5_0000;
    id_instr = ~pc; trig_en = te; trig_pc = tpc; rd_req = rq;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic run_table();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].a, tbl[i].se, tbl[i].pc, tbl[i].te, tbl[i].tpc, tbl[i].rq);
      step();
      chk($sformatf("tbl%0d state", i), 96'(state), 96'(tbl[i].st));
      chk($sformatf("tbl%0d rd_valid", i), 96'(rd_valid), 96'(tbl[i].v));
      chk($sformatf("tbl%0d rd_last", i), 96'(rd_last), 96'(tbl[i].l));
      if (tbl[i].v) chk($sformatf("tbl%0d rd_data", i), rd_data, entry(tbl[i].dpc));
      if (tbl[i].ctp) chk($sformatf("tbl%0d trig_pos", i), 96'(trig_pos), 96'(tbl[i].tp));
    end
    idle_inputs();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " state"}, 96'(state), 96'd0);
    chk({tag, " rd_valid"}, 96'(rd_valid), 96'd0);
    chk({tag, " rd_last"}, 96'(rd_last), 96'd0);
    chk({tag, " rd_data"}, rd_data, 96'd0);
    chk({tag, " trig_pos"}, 96'(trig_pos), 96'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //             a  se rq pc      st v  l  dpc    ctp tp
    tbl[0]  = mk(1, 0, 0, 32'h00, 2'd1, 0, 0, 32'h00, 0, 3'd0);
    tbl[1]  = mk(0, 1, 0, 32'h00, 2'd1, 0, 0, 32'h00, 0, 3'd0);
    tbl[2]  = mk(0, 1, 0, 32'h04, 2'd2, 0, 0, 32'h00, 0, 3'd0);
    tbl[3]  = mk(1, 1, 1, 32'h08, 2'd2, 0, 0, 32'h00, 0, 3'd0);
    tbl[4]  = mk(0, 1, 0, 32'h0C, 2'd3, 0, 0, 32'h00, 1, 3'd1);
    tbl[5]  = mk(0, 0, 1, 32'h00, 2'd3, 1, 0, 32'h00, 1, 3'd1);
    tbl[6]  = mk(1, 0, 0, 32'h00, 2'd3, 0, 0, 32'h00, 0, 3'd0);
    tbl[7]  = mk(0, 0, 1, 32'h00, 2'd3, 1, 0, 32'h04, 0, 3'd0);
    tbl[8]  = mk(0, 0, 1, 32'h00, 2'd3, 1, 0, 32'h08, 0, 3'd0);
    tbl[9]  = mk(0, 0, 1, 32'h00, 2'd0, 1, 1, 32'h0C, 0, 3'd0);
    tbl[10] = mk(0, 0, 1, 32'h00, 2'd0, 0, 0, 32'h00, 0, 3'd0);

    idle_inputs();
    reset = 1'b0;
    step();
    step();
    check_reset_state("reset");
    reset = 1'b1;

    // Basic capture and readout with a trigger two samples in
    run_table();

    // Wrapping capture: 12 samples, trigger at 0x24
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h24, 1'b0);
    step();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 1'b1, 32'h24, 1'b0);
      step();
    end
    chk("wrap state", 96'(state), 96'd3);
    chk("wrap trig_pos", 96'(trig_pos), 96'd5);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      step();
      chk($sformatf("wrap rd%0d valid", k), 96'(rd_valid), 96'd1);
      chk($sformatf("wrap rd%0d data", k), rd_data, entry(32'h10 + 32'(k * 4)));
      chk($sformatf("wrap rd%0d last", k), 96'(rd_last), 96'(k == 7));
      chk($sformatf("wrap rd%0d state", k), 96'(state), (k == 7) ? 96'd0 : 96'd3);
    end
    step();
    chk("wrap post valid", 96'(rd_valid), 96'd0);
    idle_inputs();

    // No trigger: stays armed, reads ignored
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h04, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 32'h04, 1'b0, 32'h04, 1'b1);
      step();
      chk($sformatf("notrig%0d state", i), 96'(state), 96'd1);
      chk($sformatf("notrig%0d valid", i), 96'(rd_valid), 96'd0);
    end

    // Reset mid-capture, with competing arm/sample/read
    reset = 1'b0;
    drive(1'b1, 1'b1, 32'h04, 1'b1, 32'h04, 1'b1);
    step();
    check_reset_state("rst_armed");
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 1'b1, 32'h04, 1'b0);
      step();
    end
    chk("pre_rst state", 96'(state), 96'd2);
    reset = 1'b0;
    drive(1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 1'b1);
    step();
    check_reset_state("rst_post");
    reset = 1'b1;
    idle_inputs();
    run_table();

    // Gapped sampling; idle cycles present trigger PC with sample_en low
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 1'b1, 32'h04, 1'b0);
      step();
      if (i < 3) begin
        drive(1'b0, 1'b0, 32'h04, 1'b1, 32'h04, 1'b0);
        step();
        chk($sformatf("gap%0d state", i), 96'(state), (i == 0) ? 96'd1 : 96'd2);
      end
    end
    chk("gap done state", 96'(state), 96'd3);
    chk("gap trig_pos", 96'(trig_pos), 96'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      step();
      chk($sformatf("gap rd%0d data", k), rd_data, entry(32'(k * 4)));
      chk($sformatf("gap rd%0d valid", k), 96'(rd_valid), 96'd1);
      chk($sformatf("gap rd%0d last", k), 96'(rd_last), 96'(k == 3));
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    chk("gap end valid", 96'(rd_valid), 96'd0);
    chk("gap end state", 96'(state), 96'd0);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
